// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART: frame FSM states,
// data width and a parameter sanity check used at elaboration.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic bit uart_params_ok(input int cpb, input int depth, input int stop_bits);
    return (cpb >= 4) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_fifo_unit_if.sv
// Core-side request/completion bus of the UART.
// Handshake: the controller raises go for one cycle with rors/txdata valid;
// the UART answers with a one-cycle done, rxdata valid from done onward.
interface uart_fifo_unit_if;
  import uart_pkg::*;

  logic                   go;
  logic                   rors;
  logic [UART_DATA_W-1:0] txdata;
  logic                   done;
  logic [UART_DATA_W-1:0] rxdata;

  modport master (output go, rors, txdata, input done, rxdata);
  modport slave  (input go, rors, txdata, output done, rxdata);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; a pop on an
// empty FIFO with a simultaneous push passes the pushed word straight through.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Pop is resolved first, so a full FIFO can still take a push in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && (!empty_o || push_i);
  assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_fifo_unit.sv
// Buffered UART: one-deep request register in front of TX/RX FIFOs,
// a TX frame serialiser, an RX frame sampler and sticky error flags.
module uart_fifo_unit
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH       = 16,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_fifo_unit_if.slave   bus,
  input  logic              rxd,
  output logic              txd,
  output logic              tx_full,
  output logic              rx_empty,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_err,
  output uart_state_t       dbg_tx_state,
  output uart_state_t       dbg_rx_state
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (!uart_params_ok(CLK_PER_BIT, DEPTH, STOP_BITS)) begin : g_bad_params
    $error("uart_fifo_unit: illegal CLK_PER_BIT/DEPTH/STOP_BITS");
  end

  logic                   req_valid_q, req_valid_d, req_rors_q, req_rors_d;
  logic [UART_DATA_W-1:0] req_data_q, req_data_d, rxdata_q, rxdata_d;
  logic                   done_q, done_d;
  logic                   tx_push, tx_pop, tx_empty_w, rx_push, rx_pop;
  logic [UART_DATA_W-1:0] tx_rdata, rx_rdata;

  uart_state_t            tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]          tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]             tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic                   tx_stop_q, tx_stop_d, txd_q, txd_d;
  logic [UART_DATA_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic                   rx_s1_q, rx_s2_q, rx_s3_q, ovr_evt, ferr_evt;
  logic                   overrun_q, frame_err_q;

  uart_sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .wdata_i(req_data_q), .pop_i(tx_pop),
    .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty_w));

  uart_sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .wdata_i(rx_shift_q), .pop_i(rx_pop),
    .rdata_o(rx_rdata), .full_o(), .empty_o(rx_empty));

  // Request register: a new go is only taken when nothing is pending and done is low.
  always_comb begin
    req_valid_d = req_valid_q;
    req_rors_d  = req_rors_q;
    req_data_d  = req_data_q;
    rxdata_d    = rxdata_q;
    done_d      = 1'b0;
    tx_push     = 1'b0;
    rx_pop      = 1'b0;
    if (req_valid_q) begin
      if (!req_rors_q && !tx_full) begin
        tx_push = 1'b1; done_d = 1'b1; req_valid_d = 1'b0;
      end else if (req_rors_q && !rx_empty) begin
        rx_pop = 1'b1; rxdata_d = rx_rdata; done_d = 1'b1; req_valid_d = 1'b0;
      end
    end else if (bus.go && !done_q) begin
      req_valid_d = 1'b1;
      req_rors_d  = bus.rors;
      req_data_d  = bus.txdata;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      IDLE: if (!tx_empty_w) begin
        tx_pop = 1'b1; tx_shift_d = tx_rdata; txd_d = 1'b0;
        tx_cnt_d = BIT_M1; tx_state_d = START;
      end
      START: if (tx_cnt_q == '0) begin
        tx_state_d = DATA; txd_d = tx_shift_q[0]; tx_cnt_d = BIT_M1; tx_bit_d = 3'd0;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = BIT_M1;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = STOP; txd_d = 1'b1; tx_stop_d = 1'b0;
        end else begin
          tx_shift_d = tx_shift_q >> 1; txd_d = tx_shift_q[1]; tx_bit_d = tx_bit_q + 3'd1;
        end
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      STOP: if (tx_cnt_q == '0) begin
        tx_cnt_d = BIT_M1;
        if (tx_stop_q != STOP_LAST) tx_stop_d = 1'b1;
        else if (!tx_empty_w) begin
          // Chain straight into the next frame so the line never idles between bytes.
          tx_pop = 1'b1; tx_shift_d = tx_rdata; txd_d = 1'b0; tx_state_d = START;
        end else tx_state_d = IDLE;
      end else tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_evt    = 1'b0;
    ferr_evt   = 1'b0;
    case (rx_state_q)
      IDLE: if (rx_s3_q && !rx_s2_q) begin
        rx_state_d = START; rx_cnt_d = HALF_M1;
      end
      START: if (rx_cnt_q == '0) begin
        if (!rx_s2_q) begin
          rx_state_d = DATA; rx_cnt_d = BIT_M1; rx_bit_d = 3'd0;
        end else rx_state_d = IDLE;
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[UART_DATA_W-1:1]};
        rx_cnt_d   = BIT_M1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      STOP: if (rx_cnt_q == '0) begin
        rx_state_d = IDLE;
        if (!rx_s2_q) ferr_evt = 1'b1;
        else if (!rx_empty && !rx_pop && u_rx_fifo.full_o) ovr_evt = 1'b1;
        else rx_push = 1'b1;
      end else rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0; req_rors_q <= 1'b0; req_data_q <= '0;
      rxdata_q    <= '0;   done_q     <= 1'b0;
      tx_state_q  <= IDLE; tx_cnt_q   <= '0; tx_bit_q <= '0; tx_stop_q <= 1'b0;
      tx_shift_q  <= '0;   txd_q      <= 1'b1;
      rx_state_q  <= IDLE; rx_cnt_q   <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
      rx_s1_q     <= 1'b1; rx_s2_q    <= 1'b1; rx_s3_q <= 1'b1;
      overrun_q   <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d; req_rors_q <= req_rors_d; req_data_q <= req_data_d;
      rxdata_q    <= rxdata_d;    done_q     <= done_d;
      tx_state_q  <= tx_state_d;  tx_cnt_q   <= tx_cnt_d; tx_bit_q <= tx_bit_d;
      tx_stop_q   <= tx_stop_d;   tx_shift_q <= tx_shift_d; txd_q <= txd_d;
      rx_state_q  <= rx_state_d;  rx_cnt_q   <= rx_cnt_d; rx_bit_q <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_s1_q     <= rxd; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
      overrun_q   <= (overrun_q & ~clr_err) | ovr_evt;
      frame_err_q <= (frame_err_q & ~clr_err) | ferr_evt;
    end
  end

  assign txd          = txd_q;
  assign bus.done     = done_q;
  assign bus.rxdata   = rxdata_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;
endmodule

// File: tb/tb_uart_fifo_unit.sv
// Bench for uart_fifo_unit: one instance with one stop bit (loopback-capable)
// and one with two stop bits, checked against frame and FIFO models.
module tb_uart_fifo_unit;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo_unit_if bus1();
  uart_fifo_unit_if bus2();

  logic rxd_drv = 1'b1, loop_en = 1'b0, clr_err = 1'b0;
  logic rxd1, txd1, tx_full1, rx_empty1, ovr1, ferr1;
  logic txd2, tx_full2, rx_empty2, ovr2, ferr2;
  uart_state_t txs1, rxs1, txs2, rxs2;

  assign rxd1 = loop_en ? txd1 : rxd_drv;

  uart_fifo_unit #(.CLK_PER_BIT(CPB), .DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .rxd(rxd1), .txd(txd1), .tx_full(tx_full1),
    .rx_empty(rx_empty1), .overrun(ovr1), .frame_err(ferr1), .clr_err(clr_err),
    .dbg_tx_state(txs1), .dbg_rx_state(rxs1));

  uart_fifo_unit #(.CLK_PER_BIT(CPB), .DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .rxd(1'b1), .txd(txd2), .tx_full(tx_full2),
    .rx_empty(rx_empty2), .overrun(ovr2), .frame_err(ferr2), .clr_err(1'b0),
    .dbg_tx_state(txs2), .dbg_rx_state(rxs2));

  int n_cmp = 0, n_bad = 0, last_done_cyc = 0;
  logic [7:0] exp_q[$];
  logic       exp_bits[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_empty;
    logic       exp_ovr;
    logic       exp_ferr;
  } rx_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  function automatic logic done_of(input int w);
    return (w == 1) ? bus1.done : bus2.done;
  endfunction

  function automatic logic txd_of(input int w);
    return (w == 1) ? txd1 : txd2;
  endfunction

  // Serial frame model: start 0, data LSB first, then the stop bits.
  task automatic add_frame(input logic [7:0] b, input int stops);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
  endtask

  task automatic go_req(input int w, input logic r, input logic [7:0] d);
    @(negedge clk);
    if (w == 1) begin bus1.go = 1'b1; bus1.rors = r; bus1.txdata = d; end
    else        begin bus2.go = 1'b1; bus2.rors = r; bus2.txdata = d; end
    @(posedge clk); #1;
    bus1.go = 1'b0;
    bus2.go = 1'b0;
  endtask

  task automatic wait_done(input int w, input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (done_of(w)) begin cycles = i; last_done_cyc = cyc; break; end
    end
    if (cycles < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", max);
    end
  endtask

  task automatic send(input int w, input logic [7:0] d, output int cycles);
    go_req(w, 1'b0, d);
    wait_done(w, 1000, cycles);
    tick();
  endtask

  task automatic recv(output logic [7:0] d, output int cycles);
    go_req(1, 1'b1, 8'h00);
    wait_done(1, 1000, cycles);
    d = bus1.rxdata;
    tick();
  endtask

  // Sample bit centres of a stream that started at edge s.
  task automatic stream_abs(input int w, input int s, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      wait_until(s + CPB/2 + CPB*i);
      check($sformatf("txd%0d_bit%0d", w, i), txd_of(w), exp_bits.pop_front());
    end
  endtask

  task automatic find_start(input int w, input int max, output int s);
    s = -1;
    for (int i = 0; i < max; i++) begin
      if (txd_of(w) == 1'b0) begin s = cyc; break; end
      tick();
    end
    if (s < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL tx_start_timeout: got txd high expected start bit within %0d cycles", max);
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop);
    @(negedge clk); rxd_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rxd_drv = d[i]; repeat (CPB) @(negedge clk); end
    rxd_drv = stop;
    repeat (CPB) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    #800000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got no end of test expected finish before 800us");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rx_vec_t    vt[6];
    logic [7:0] bv[6];
    int         cv[6];
    int         c, s1, d6, n;
    logic [7:0] d;

    bus1.go = 1'b0; bus1.rors = 1'b0; bus1.txdata = '0;
    bus2.go = 1'b0; bus2.rors = 1'b0; bus2.txdata = '0;

    vt[0] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'hA2, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{8'h66, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", txd1, 1); check("rst_done", bus1.done, 0);
    check("rst_rxdata", bus1.rxdata, 0); check("rst_ovr", ovr1, 0);
    check("rst_ferr", ferr1, 0); check("rst_tx_full", tx_full1, 0);
    check("rst_rx_empty", rx_empty1, 1); check("rst_tx_state", txs1, IDLE);
    check("rst_rx_state", rxs1, IDLE); check("rst_txd2", txd2, 1);
    rst = 1'b0;
    tick_n(3);

    // Single byte 0xA5: latency, bit pattern, frame length
    go_req(1, 1'b0, 8'hA5);
    wait_done(1, 20, c);
    check("send_latency", c, 1);
    check("txd_before_start", txd1, 1);
    tick();
    s1 = cyc;
    check("txd_start", txd1, 0);
    add_frame(8'hA5, 1);
    stream_abs(1, s1, 10);
    wait_until(s1 + 10*CPB - 1);
    check("a5_last_cycle_stop", txs1, STOP);
    tick();
    check("a5_frame_len_idle", txs1, IDLE);

    // Six random bytes: five accepted at once, sixth waits for a free slot
    for (int k = 0; k < 6; k++) begin bv[k] = 8'($urandom_range(0, 255)); add_frame(bv[k], 1); end
    d6 = 0;
    fork
      begin find_start(1, 100, s1); stream_abs(1, s1, 60); end
      begin
        for (int k = 0; k < 6; k++) begin
          send(1, bv[k], cv[k]);
          if (k == 4) check("tx_full_after5", tx_full1, 1);
        end
        d6 = last_done_cyc;
      end
    join
    for (int k = 0; k < 5; k++) check($sformatf("burst_lat%0d", k), cv[k], 1);
    check("sixth_blocked", (cv[5] > 1), 1);
    check("sixth_done_time", d6 - s1, 10*CPB + 1);
    tick_n(20);
    check("burst_end_idle", txs1, IDLE);

    // Loopback: receive blocks until the byte comes back
    loop_en = 1'b1;
    tick_n(4);
    send(1, 8'h3C, c);
    s1 = cyc;
    check("loop_txd_start", txd1, 0);
    recv(d, c);
    check("loop_rx_blocked", (c > 1), 1);
    check("loop_rxdata", d, 8'h3C);
    check("loop_rx_time", (last_done_cyc >= s1 + 9*CPB + 6) && (last_done_cyc <= s1 + 10*CPB), 1);

    // Randomised loopback bursts against a byte queue
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        send(1, d, c);
        check("rand_send_lat", c, 1);
      end
      for (int k = 0; k < n; k++) begin
        recv(d, c);
        check($sformatf("rand_rx_r%0d_k%0d", r, k), d, exp_q.pop_front());
      end
    end
    tick_n(200);
    loop_en = 1'b0;
    check("loop_end_empty", rx_empty1, 1);
    check("loop_end_ovr", ovr1, 0);
    check("loop_end_ferr", ferr1, 0);

    // RX frame table: fill, overrun, framing error
    for (int i = 0; i < 6; i++) begin
      drive_rx(vt[i].data, vt[i].stop);
      if (vt[i].stop && !vt[i].exp_ovr) exp_q.push_back(vt[i].data);
      check($sformatf("rxv%0d_empty", i), rx_empty1, vt[i].exp_empty);
      check($sformatf("rxv%0d_ovr", i), ovr1, vt[i].exp_ovr);
      check($sformatf("rxv%0d_ferr", i), ferr1, vt[i].exp_ferr);
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("clr_ovr", ovr1, 0);
    check("clr_ferr", ferr1, 0);
    for (int k = 0; k < 4; k++) begin
      recv(d, c);
      check($sformatf("rxv_pop%0d_lat", k), c, 1);
      check($sformatf("rxv_pop%0d_data", k), d, exp_q.pop_front());
    end
    check("rxv_drained", rx_empty1, 1);

    // False start glitch, then a clean frame
    @(negedge clk); rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_empty", rx_empty1, 1);
    check("glitch_ferr", ferr1, 0);
    check("glitch_ovr", ovr1, 0);
    check("glitch_rx_state", rxs1, IDLE);
    drive_rx(8'h5A, 1'b1);
    recv(d, c);
    check("after_glitch_rx", d, 8'h5A);

    // Reset in the middle of a TX and an RX frame
    drive_rx(8'h00, 1'b0);
    check("ferr_set_again", ferr1, 1);
    fork
      drive_rx(8'hFF, 1'b1);
      begin
        send(1, 8'h00, c);
        tick_n(40);
        @(negedge clk);
        check("txd_low_before_rst", txd1, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_txd", txd1, 1); check("mid_rst_done", bus1.done, 0);
        check("mid_rst_rxdata", bus1.rxdata, 0); check("mid_rst_ferr", ferr1, 0);
        check("mid_rst_ovr", ovr1, 0); check("mid_rst_tx_full", tx_full1, 0);
        check("mid_rst_rx_empty", rx_empty1, 1); check("mid_rst_tx_state", txs1, IDLE);
        check("mid_rst_rx_state", rxs1, IDLE);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    tick_n(10);
    check("post_rst_rx_empty", rx_empty1, 1);
    check("post_rst_ferr", ferr1, 0);
    check("post_rst_txd", txd1, 1);
    check("post_rst_tx_state", txs1, IDLE);

    // Two stop bits, back-to-back frames
    bv[0] = 8'($urandom_range(0, 255));
    bv[1] = 8'($urandom_range(0, 255));
    add_frame(bv[0], 2);
    send(2, bv[0], c);
    s1 = cyc;
    check("sb2_start", txd2, 0);
    send(2, bv[1], c);
    check("sb2_second_lat", c, 1);
    stream_abs(2, s1, 11);
    wait_until(s1 + 11*CPB - 1);
    check("sb2_stop2_last_cycle", txd2, 1);
    check("sb2_stop_state", txs2, STOP);
    tick();
    check("sb2_frame2_start", txd2, 0);
    add_frame(bv[1], 2);
    stream_abs(2, s1 + 11*CPB, 11);
    wait_until(s1 + 22*CPB);
    check("sb2_end_idle", txs2, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
